// File: rtl/mc6803_sci.sv
// MC6803 serial communications interface: CPU register file, NRZ transmitter with
// start-up preamble, mid-bit sampling receiver, and wake-up idle-line detector.
module mc6803_sci #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic       vma,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       rxd,
    output logic       txd,
    output logic       irq_sci
);
    // state       | meaning
    // TX_IDLE     | line marking, waiting for TE=1 and TDRE=0
    // TX_PREAMBLE | ten bit times of marking after TE rises
    // TX_START    | start bit (0)
    // TX_DATA     | eight data bits, LSB first
    // TX_STOP     | stop bit (1); back-to-back start if TDR is pending
    // RX_IDLE     | waiting for a falling edge on the synchronised line
    // RX_START    | half a bit time to the middle of the start bit
    // RX_DATA     | eight samples one bit time apart
    // RX_STOP     | stop sample; holds here on a framing error until the line marks
    typedef enum logic [2:0] {TX_IDLE, TX_PREAMBLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [1:0] A_RMCR  = 2'd0;
    localparam logic [1:0] A_TRCSR = 2'd1;
    localparam logic [1:0] A_RDR   = 2'd2;
    localparam logic [1:0] A_TDR   = 2'd3;

    logic [1:0]  ss_q, ss_d;
    logic        rie_q, rie_d, re_q, re_d, tie_q, tie_d, te_q, te_d, wu_q, wu_d;
    logic        rdrf_q, rdrf_d, orfe_q, orfe_d, tdre_q, tdre_d;
    logic [7:0]  rdr_q, rdr_d, tdr_q, tdr_d;
    logic        clr_arm_q, clr_arm_d;
    logic [11:0] prs_q, prs_d;
    logic [3:0]  wu_ones_q, wu_ones_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic        rx_prev_q, rx_prev_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_load_q, tx_load_d;
    logic        txd_q, txd_d;

    rx_state_t   rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_ferr_q, rx_ferr_d;

    logic [15:0] n_m1, pre_m1;
    logic [11:0] half_m1;
    logic        access, wr, rd, wr_rmcr, wr_trcsr, wr_tdr, rd_trcsr, rd_rdr;
    logic        te_set, rx_s, rx_fall, tx_tc, rx_tc, prs_tick;
    logic        rx_ok, rx_bad, rx_flag_ev;

    assign access   = sel & vma;
    assign wr       = access & ~rw;
    assign rd       = access & rw;
    assign wr_rmcr  = wr & (addr == A_RMCR);
    assign wr_trcsr = wr & (addr == A_TRCSR);
    assign wr_tdr   = wr & (addr == A_TDR);
    assign rd_trcsr = rd & (addr == A_TRCSR);
    assign rd_rdr   = rd & (addr == A_RDR);
    assign te_set   = wr_trcsr & data_in[1] & ~te_q;
    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign rx_fall  = rx_prev_q & ~rx_s;
    assign tx_tc    = (tx_cnt_q == 16'd0);
    assign rx_tc    = (rx_cnt_q == 12'd0);
    assign prs_tick = (prs_q == 12'd0);

    always_comb begin
        n_m1    = 16'd15;
        half_m1 = 12'd7;
        pre_m1  = 16'd159;
        case (ss_q)
            2'b01: begin n_m1 = 16'd127;  half_m1 = 12'd63;   pre_m1 = 16'd1279;  end
            2'b10: begin n_m1 = 16'd1023; half_m1 = 12'd511;  pre_m1 = 16'd10239; end
            2'b11: begin n_m1 = 16'd4095; half_m1 = 12'd2047; pre_m1 = 16'd40959; end
            default: ;
        endcase
    end

    always_comb begin
        data_out = 8'h00;
        case (addr)
            A_RMCR:  data_out = {6'b0, ss_q};
            A_TRCSR: data_out = {rdrf_q, orfe_q, tdre_q, rie_q, re_q, tie_q, te_q, wu_q};
            A_RDR:   data_out = rdr_q;
            default: data_out = 8'h00;
        endcase
    end

    assign irq_sci = (rie_q & (rdrf_q | orfe_q)) | (tie_q & tdre_q);
    assign txd     = txd_q;

    always_comb begin
        sync_d[0] = rxd;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_load_d  = 1'b0;
        txd_d      = txd_q;
        if (tx_state_q != TX_IDLE && !tx_tc) tx_cnt_d = tx_cnt_q - 16'd1;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (te_set) begin
                    tx_state_d = TX_PREAMBLE;
                    tx_cnt_d   = pre_m1;
                end else if (te_q && !tdre_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = n_m1;
                    tx_sh_d    = tdr_q;
                    tx_load_d  = 1'b1;
                    txd_d      = 1'b0;
                end
            end
            TX_PREAMBLE: begin
                txd_d = 1'b1;
                if (tx_tc) tx_state_d = TX_IDLE;
            end
            TX_START: begin
                if (tx_tc) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = n_m1;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_sh_q[0];
                end
            end
            TX_DATA: begin
                if (tx_tc) begin
                    tx_cnt_d = n_m1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_tc) begin
                    // A pending byte follows immediately; TE low lets the line go idle.
                    if (te_q && !tdre_q) begin
                        tx_state_d = TX_START;
                        tx_cnt_d   = n_m1;
                        tx_sh_d    = tdr_q;
                        tx_load_d  = 1'b1;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_ferr_d  = rx_ferr_q;
        rx_prev_d  = rx_s;
        rx_ok      = 1'b0;
        rx_bad     = 1'b0;
        if (rx_state_q != RX_IDLE && !rx_tc) rx_cnt_d = rx_cnt_q - 12'd1;
        if (!re_q) begin
            rx_state_d = RX_IDLE;
            rx_ferr_d  = 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = half_m1;
                    end
                end
                RX_START: begin
                    if (rx_tc) begin
                        if (rx_s) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_cnt_d   = n_m1[11:0];
                            rx_bit_d   = 3'd0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tc) begin
                        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                        rx_cnt_d = n_m1[11:0];
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_ferr_q) begin
                        if (rx_s) begin
                            rx_state_d = RX_IDLE;
                            rx_ferr_d  = 1'b0;
                        end
                    end else if (rx_tc) begin
                        if (rx_s) begin
                            rx_ok      = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_bad    = 1'b1;
                            rx_ferr_d = 1'b1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    assign rx_flag_ev = (rx_ok | rx_bad) & ~wu_q;

    always_comb begin
        ss_d      = ss_q;
        rie_d     = rie_q;
        re_d      = re_q;
        tie_d     = tie_q;
        te_d      = te_q;
        wu_d      = wu_q;
        rdrf_d    = rdrf_q;
        orfe_d    = orfe_q;
        tdre_d    = tdre_q;
        rdr_d     = rdr_q;
        tdr_d     = tdr_q;
        clr_arm_d = clr_arm_q;
        wu_ones_d = wu_ones_q;
        prs_d     = prs_tick ? n_m1[11:0] : prs_q - 12'd1;

        // Wake-up: count consecutive marking samples at the bit rate.
        if (!wu_q) begin
            wu_ones_d = 4'd0;
        end else if (prs_tick) begin
            if (!rx_s) begin
                wu_ones_d = 4'd0;
            end else if (wu_ones_q == 4'd9) begin
                wu_ones_d = 4'd0;
                wu_d      = 1'b0;
            end else begin
                wu_ones_d = wu_ones_q + 4'd1;
            end
        end

        if (wr_rmcr) begin
            ss_d  = data_in[1:0];
            prs_d = 12'd0;
        end
        if (wr_trcsr) {rie_d, re_d, tie_d, te_d, wu_d} = data_in[4:0];
        if (wr_tdr) begin
            tdr_d  = data_in;
            tdre_d = 1'b0;
        end else if (tx_load_q) begin
            tdre_d = 1'b1;
        end

        if (rd_trcsr && (rdrf_q || orfe_q)) clr_arm_d = 1'b1;
        // A receive completing on the clearing read keeps its own flag outcome.
        if (rd_rdr && clr_arm_q) begin
            clr_arm_d = 1'b0;
            if (!rx_flag_ev) begin
                rdrf_d = 1'b0;
                orfe_d = 1'b0;
            end
        end
        if (rx_flag_ev) begin
            if (rx_bad || rdrf_q) begin
                orfe_d = 1'b1;
            end else begin
                rdr_d  = rx_sh_q;
                rdrf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            ss_q       <= 2'b00;
            rie_q      <= 1'b0;
            re_q       <= 1'b0;
            tie_q      <= 1'b0;
            te_q       <= 1'b0;
            wu_q       <= 1'b0;
            rdrf_q     <= 1'b0;
            orfe_q     <= 1'b0;
            tdre_q     <= 1'b1;
            rdr_q      <= 8'h00;
            tdr_q      <= 8'h00;
            clr_arm_q  <= 1'b0;
            prs_q      <= 12'd0;
            wu_ones_q  <= 4'd0;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            tx_load_q  <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 12'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_ferr_q  <= 1'b0;
        end else begin
            ss_q       <= ss_d;
            rie_q      <= rie_d;
            re_q       <= re_d;
            tie_q      <= tie_d;
            te_q       <= te_d;
            wu_q       <= wu_d;
            rdrf_q     <= rdrf_d;
            orfe_q     <= orfe_d;
            tdre_q     <= tdre_d;
            rdr_q      <= rdr_d;
            tdr_q      <= tdr_d;
            clr_arm_q  <= clr_arm_d;
            prs_q      <= prs_d;
            wu_ones_q  <= wu_ones_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_load_q  <= tx_load_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule

// File: doc/mc6803_sci.md
MC6803_SCI -- requirements
Module: mc6803_sci

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of rxd synchroniser flops.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge; one clk equals one E cycle.
REQ-003 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port sel  in  1  chip select from the CPU address decoder, high for $0010-$0013.
REQ-005 SHALL have port addr  in  2  register offset: 0=RMCR, 1=TRCSR, 2=RDR, 3=TDR.
REQ-006 SHALL have port vma  in  1  valid memory access strobe from the core.
REQ-007 SHALL have port rw  in  1  1=read, 0=write.
REQ-008 SHALL have port data_in  in  8  CPU write data.
REQ-009 SHALL have port data_out  out  8  register read data.
REQ-010 SHALL have port rxd  in  1  serial receive line, asynchronous.
REQ-011 SHALL have port txd  out  1  serial transmit line.
REQ-012 SHALL have port irq_sci  out  1  level interrupt to the core's irq_sci input.

Function
REQ-013 SHALL define access as sel&vma; a write occurs on a rising edge with access&~rw, a read side-effect on a rising edge with access&rw.
REQ-014 SHALL drive data_out combinationally from addr: RMCR={6'b0,SS1,SS0}, TRCSR={RDRF,ORFE,TDRE,RIE,RE,TIE,TE,WU}, RDR, and TDR reads as $00.
REQ-015 SHALL make RMCR[1:0] writable; writes to bits 7:2 are ignored.
REQ-016 SHALL make only TRCSR bits 4:0 writable; RDRF, ORFE and TDRE are read-only status bits.
REQ-017 SHALL set bit period N from SS: 00=16, 01=128, 10=1024, 11=4096 clk cycles.
REQ-018 SHALL restart the prescaler when RMCR is written.
REQ-019 SHALL synchronise rxd through SYNC_STAGES flops before any use.
REQ-020 Transmit: a TDR write SHALL load TDR and clear TDRE on the same edge.
REQ-021 Transmit: TX FSM states SHALL be IDLE, PREAMBLE, START, DATA, STOP.
REQ-022 Transmit: on TE 0->1 the FSM SHALL enter PREAMBLE and hold txd=1 for 10*N cycles.
REQ-023 Transmit: in IDLE with TE=1 and TDRE=0, the FSM SHALL copy TDR to the shifter, set TDRE on the next edge, and enter START.
REQ-024 Transmit: the frame SHALL be START (txd=0), then DATA (8 bits LSB first), then STOP (txd=1), each lasting exactly N cycles.
REQ-025 Transmit: after STOP, if TDRE=0 the FSM SHALL go directly to START with no idle gap, otherwise to IDLE.
REQ-026 Transmit: TE cleared mid-frame SHALL let the current frame complete, then go to IDLE with txd=1.
REQ-027 Receive: RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-028 Receive: with RE=1, a synchronised 1->0 on rxd in IDLE SHALL enter START.
REQ-029 Receive: at N/2 cycles, if rxd=1 the FSM SHALL return to IDLE (false start), otherwise go to DATA.
REQ-030 Receive: each data bit SHALL be sampled N cycles after the previous sample, 8 bits LSB first; the stop bit is sampled N cycles later.
REQ-031 Receive: on stop=1 with RDRF=0, RDR SHALL load the shifter and RDRF is set.
REQ-032 Receive: on stop=1 with RDRF=1, ORFE SHALL be set and RDR is left unchanged (overrun).
REQ-033 Receive: on stop=0, ORFE SHALL be set, RDR and RDRF are unchanged, and the FSM waits for rxd=1 before returning to IDLE (framing error).
REQ-034 Receive: RE cleared SHALL abort reception to IDLE at once; RDRF and ORFE are held.
REQ-035 Flag clear: a TRCSR read with RDRF|ORFE set SHALL arm a clear.
REQ-036 Flag clear: the next RDR read SHALL clear both RDRF and ORFE and disarm.
REQ-037 Flag clear: an RDR read without arm SHALL return data and leave the flags alone.
REQ-038 Flag clear: a receive completing on the same edge as the clearing RDR read SHALL win; the new flag state stands.
REQ-039 Wake-up: while WU=1 the receiver SHALL discard frames (no RDR, RDRF or ORFE update).
REQ-040 Wake-up: WU SHALL self-clear after 10 consecutive sampled ones at bit rate.
REQ-041 SHALL drive irq_sci = (RIE&(RDRF|ORFE)) | (TIE&TDRE), registered-free.

Reset
REQ-042 While RST_N=0 all state SHALL be forced asynchronously: RMCR=$00, TRCSR=$20, RDR=$00, TDR=$00, both FSMs IDLE, prescaler=0, clear-arm=0, synchroniser=1s, txd=1, irq_sci=0.
REQ-043 Release of reset mid-frame SHALL NOT resume the frame; the line stays idle until software re-enables it.

Verification
REQ-044 Reset, then SS=00, TE=1, wait 160 cycles, write TDR=$A5: txd stays 1 for 160 cycles, then 0, 1,0,1,0,0,1,0,1, 1, each 16 cycles; TDRE is 0 after the write and 1 one cycle after START begins.
REQ-045 RE=1, drive frame $3C at N=16: RDRF=1 within 10*16+SYNC_STAGES+1 cycles, RDR=$3C; reading TRCSR then RDR clears RDRF.
REQ-046 Two frames $11 and $22 sent without reading: ORFE=1, RDR=$11, RDRF=1; TRCSR+RDR read clears both flags.
REQ-047 Frame with stop bit 0: ORFE=1, RDRF=0; a 4-cycle rxd low glitch gives no start and no flag.
REQ-048 RIE=1 with receive complete: irq_sci=1; with TIE=1 and TDRE=1: irq_sci=1; RST_N pulsed low mid-transmit: txd=1 and TRCSR=$20 immediately, asynchronously.
